// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter sharing one SPI master
// among three requesters, with per-transaction timeout.
module spi_txn_arbiter #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] tx_data0,
    input  logic [15:0] tx_data1,
    input  logic [15:0] tx_data2,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        err,
    output logic [15:0] rx_data,
    output logic [2:0]  cs_sel,
    output logic [15:0] m_data,
    input  logic        m_done,
    input  logic [15:0] m_rx
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  win;
    logic [1:0]  win_nx;
    logic [1:0]  last;
    logic [1:0]  last_nx;
    logic [7:0]  timer;
    logic [7:0]  timer_nx;
    logic [2:0]  gnt_nx;
    logic [2:0]  done_nx;
    logic        err_nx;
    logic [15:0] rx_nx;
    logic [15:0] md_nx;
    logic [1:0]  pick;
    logic [2:0]  oh_pick;
    logic [15:0] tx_pick;

    // Slave select is the grant itself, so it is never live outside BUSY.
    assign cs_sel = gnt;

    // Round-robin pick: search starts one past the last served index.
    always_comb begin
        pick = 2'd0;
        unique case (last)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Decode the winner into a one-hot grant and its write word.
    always_comb begin
        oh_pick = 3'b001 << pick;
        unique case (pick)
            2'd0:    tx_pick = tx_data0;
            2'd1:    tx_pick = tx_data1;
            default: tx_pick = tx_data2;
        endcase
    end

    // Next state and next register values; m_done beats the timeout.
    always_comb begin
        state_nx = state;
        win_nx   = win;
        last_nx  = last;
        timer_nx = timer;
        gnt_nx   = gnt;
        done_nx  = 3'b000;
        err_nx   = 1'b0;
        rx_nx    = rx_data;
        md_nx    = m_data;
        unique case (state)
            IDLE: begin
                gnt_nx = 3'b000;
                if (|req) begin
                    state_nx = BUSY;
                    win_nx   = pick;
                    gnt_nx   = oh_pick;
                    md_nx    = tx_pick;
                    timer_nx = 8'd0;
                end
            end
            BUSY: begin
                timer_nx = timer + 8'd1;
                if (m_done) begin
                    rx_nx    = m_rx;
                    done_nx  = gnt;
                    gnt_nx   = 3'b000;
                    state_nx = RESP;
                end else if (timer == TMAX) begin
                    rx_nx    = 16'h0000;
                    err_nx   = 1'b1;
                    done_nx  = gnt;
                    gnt_nx   = 3'b000;
                    state_nx = RESP;
                end
            end
            default: begin
                gnt_nx   = 3'b000;
                last_nx  = win;
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered outputs and arbitration bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= 3'b000;
            done    <= 3'b000;
            err     <= 1'b0;
            rx_data <= 16'h0000;
            m_data  <= 16'h0000;
            timer   <= 8'd0;
            last    <= 2'd2;
            win     <= 2'd0;
        end else begin
            gnt     <= gnt_nx;
            done    <= done_nx;
            err     <= err_nx;
            rx_data <= rx_nx;
            m_data  <= md_nx;
            timer   <= timer_nx;
            last    <= last_nx;
            win     <= win_nx;
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed self-checking bench for
// spi_txn_arbiter with hand-computed expectations.
module tb_spi_txn_arbiter;

    localparam int TO = 40;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] tx_data0;
    logic [15:0] tx_data1;
    logic [15:0] tx_data2;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        err;
    logic [15:0] rx_data;
    logic [2:0]  cs_sel;
    logic [15:0] m_data;
    logic        m_done;
    logic [15:0] m_rx;

    int checks;
    int errors;

    spi_txn_arbiter #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .tx_data0 (tx_data0),
        .tx_data1 (tx_data1),
        .tx_data2 (tx_data2),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rx_data  (rx_data),
        .cs_sel   (cs_sel),
        .m_data   (m_data),
        .m_done   (m_done),
        .m_rx     (m_rx)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_mdone(input logic [15:0] rx);
        m_done = 1'b1;
        m_rx   = rx;
        tick();
        m_done = 1'b0;
        m_rx   = 16'h0000;
    endtask

    logic [2:0] order [4];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        req      = 3'b000;
        tx_data0 = 16'h0F0F;
        tx_data1 = 16'hA5C3;
        tx_data2 = 16'hC0DE;
        m_done   = 1'b0;
        m_rx     = 16'h0000;
        ticks(2);
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_cs", 32'(cs_sel), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rx", 32'(rx_data), 32'h0);
        check("rst_mdata", 32'(m_data), 32'h0);
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        // single request from requester 1
        req = 3'b010;
        tick();
        check("t1_gnt", 32'(gnt), 32'h2);
        check("t1_cs", 32'(cs_sel), 32'h2);
        check("t1_mdata", 32'(m_data), 32'hA5C3);
        ticks(16);
        check("t1_hold", 32'(cs_sel), 32'h2);
        check("t1_nodone", 32'(done), 32'h0);
        pulse_mdone(16'h1234);
        check("t1_done", 32'(done), 32'h2);
        check("t1_err", 32'(err), 32'h0);
        check("t1_rx", 32'(rx_data), 32'h1234);
        check("t1_cs_resp", 32'(cs_sel), 32'h0);
        req = 3'b000;
        tick();
        check("t1_done_off", 32'(done), 32'h0);

        // spurious m_done in IDLE
        pulse_mdone(16'hFFFF);
        check("t2_rx", 32'(rx_data), 32'h1234);
        check("t2_done", 32'(done), 32'h0);

        // timeout on requester 0
        req = 3'b001;
        tick();
        check("t3_gnt", 32'(gnt), 32'h1);
        check("t3_mdata", 32'(m_data), 32'h0F0F);
        ticks(TO - 1);
        check("t3_early", 32'(done), 32'h0);
        check("t3_cs_hold", 32'(cs_sel), 32'h1);
        tick();
        check("t3_done", 32'(done), 32'h1);
        check("t3_err", 32'(err), 32'h1);
        check("t3_rx", 32'(rx_data), 32'h0);
        check("t3_cs_resp", 32'(cs_sel), 32'h0);
        req = 3'b000;
        tick();
        check("t3_err_off", 32'(err), 32'h0);
        check("t3_done_off", 32'(done), 32'h0);

        // m_done coincides with the last timer cycle
        req = 3'b010;
        tick();
        check("t4_gnt", 32'(gnt), 32'h2);
        ticks(TO - 1);
        pulse_mdone(16'hBEEF);
        check("t4_done", 32'(done), 32'h2);
        check("t4_err", 32'(err), 32'h0);
        check("t4_rx", 32'(rx_data), 32'hBEEF);
        req = 3'b000;
        tick();

        // request dropped during BUSY
        req = 3'b100;
        tick();
        check("t5_gnt", 32'(gnt), 32'h4);
        check("t5_mdata", 32'(m_data), 32'hC0DE);
        req = 3'b000;
        ticks(5);
        check("t5_hold", 32'(gnt), 32'h4);
        pulse_mdone(16'h5A5A);
        check("t5_done", 32'(done), 32'h4);
        check("t5_rx", 32'(rx_data), 32'h5A5A);
        tick();
        check("t5_idle", 32'(gnt), 32'h0);

        // reset while requester 2 is granted
        req = 3'b100;
        tick();
        check("t6_gnt", 32'(gnt), 32'h4);
        ticks(3);
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
        check("t6_gnt", 32'(gnt), 32'h0);
        check("t6_cs", 32'(cs_sel), 32'h0);
        check("t6_done", 32'(done), 32'h0);
        check("t6_rx", 32'(rx_data), 32'h0);
        check("t6_mdata", 32'(m_data), 32'h0);
        tick();
        check("t6_nodone", 32'(done), 32'h0);

        // fairness with all requesters active after reset
        order[0] = 3'b001;
        order[1] = 3'b010;
        order[2] = 3'b100;
        order[3] = 3'b001;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(order[i]));
            check("rr_cs", 32'(cs_sel), 32'(order[i]));
            ticks(2);
            pulse_mdone(16'(i + 1));
            check("rr_done", 32'(done), 32'(order[i]));
            check("rr_rx", 32'(rx_data), 32'(i + 1));
            check("rr_cs_resp", 32'(cs_sel), 32'h0);
            tick();
            check("rr_cs_idle", 32'(cs_sel), 32'h0);
            check("rr_done_off", 32'(done), 32'h0);
        end
        req = 3'b000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 40, max cycles in BUSY awaiting m_done before error termination (legal range 2..255).
REQ-002 Port: clk  in  1  single clock; all logic on posedge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req  in  3  per-requester transaction request, bit i = requester i; held high until done[i].
REQ-005 Port: tx_data0 / tx_data1 / tx_data2  in  16 each  write word of requester 0/1/2.
REQ-006 Port: gnt  out  3  one-hot grant, high for the whole transaction.
REQ-007 Port: done  out  3  one-cycle completion pulse, bit i = requester i.
REQ-008 Port: err  out  1  high with done when the transaction timed out.
REQ-009 Port: rx_data  out  16  read word of the last completed transaction.
REQ-010 Port: cs_sel  out  3  one-hot slave select to the SPI master (bit0 = slave 1, bit1 = slave 2, bit2 = slave 3); requester i drives slave i+1.
REQ-011 Port: m_data  out  16  write word presented to the SPI master.
REQ-012 Port: m_done  in  1  one-cycle pulse from the SPI master: transfer complete.
REQ-013 Port: m_rx  in  16  SPI master read word, valid while m_done is high.

Function
REQ-014 FSM states: IDLE, BUSY, RESP; all outputs are registered.
REQ-015 IDLE: if req != 0, select a winner by round-robin, then in the next cycle enter BUSY with gnt = cs_sel = one-hot(winner), m_data = tx_data[winner] (latched), timer = 0.
REQ-016 Round-robin: search order starts at (last + 1) mod 3, where last is the most recently served index; last = 2 after reset, so the first-search order is 0, 1, 2.
REQ-017 IDLE with req == 0: stay in IDLE; gnt, cs_sel and done are 0.
REQ-018 BUSY: gnt, cs_sel and m_data are held constant; the timer increments by 1 each cycle; req changes are ignored (a dropped req does not abort the transaction).
REQ-019 BUSY with m_done = 1: rx_data <= m_rx, err <= 0, done[winner] <= 1, next state is RESP.
REQ-020 BUSY with timer == TIMEOUT-1 and m_done = 0: rx_data <= 0, err <= 1, done[winner] <= 1, next state is RESP.
REQ-021 If m_done and the timeout coincide, m_done wins: no error is reported and m_rx is captured.
REQ-022 RESP (exactly 1 cycle): done and err are visible; gnt = cs_sel = 0; last <= winner; next state is IDLE.
REQ-023 done and err are 0 in every cycle outside RESP; rx_data holds its value until the next RESP.
REQ-024 m_done in IDLE or RESP is ignored and does not change rx_data.
REQ-025 Minimum spacing between transactions: 1 deselect cycle (RESP) plus 1 arbitration cycle (IDLE); cs_sel never switches directly from one slave to another.
REQ-026 Latency from req rising (FSM in IDLE) to gnt/cs_sel high: 1 cycle.
REQ-027 Latency from m_done to the done pulse: 1 cycle.

Reset
REQ-028 rst = 1 at any posedge: state = IDLE, gnt = cs_sel = done = 0, err = 0, rx_data = 0, m_data = 0, timer = 0, last = 2.
REQ-029 Reset mid-BUSY aborts the transaction: cs_sel drops the next cycle and no done pulse is issued for it.

Verification
REQ-030 Single request: req = 3'b010, tx_data1 = 16'hA5C3, m_done after 17 cycles with m_rx = 16'h1234 -> gnt = cs_sel = 3'b010 and m_data = 16'hA5C3 in BUSY; then done = 3'b010, err = 0, rx_data = 16'h1234.
REQ-031 Fairness: req = 3'b111 held, each transfer completed by m_done -> grant order 0, 1, 2, 0, ..., with one RESP cycle and one IDLE cycle (cs_sel = 0) between grants.
REQ-032 Timeout: req = 3'b001, m_done never asserted -> done = 3'b001 and err = 1 exactly TIMEOUT cycles after BUSY entry; rx_data = 0; cs_sel = 0 in RESP.
REQ-033 Coincidence: m_done pulses on the cycle with timer == TIMEOUT-1, m_rx = 16'hBEEF -> err = 0, rx_data = 16'hBEEF.
REQ-034 Reset mid-BUSY: rst pulsed while gnt = 3'b100 -> all outputs 0 the next cycle, no done pulse; the next req = 3'b111 is granted to requester 0 first.
REQ-035 Spurious and dropped: m_done pulsed in IDLE -> rx_data unchanged; req deasserted during BUSY -> transaction completes and done still pulses.
